fir_out_decimator: RTL

//   Downstream stage of fir_filter: consumes the 16-bit y_out stream and keeps every DECIM-th valid sample.

---
 rtl/fir_out_decimator.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/fir_out_decimator.sv
// Output stage for fir_filter. It keeps every DECIM-th valid y_out sample and
// rounds it half-up by SHIFT bits. The result is saturated to OUT_W bits and
// queued in a show-ahead FIFO that feeds a valid/ready sink.
// Monitoring outputs:
//   sat_flag  - one-cycle pulse when a kept sample saturates
//   overflow  - sticky, set when a sample is dropped because the FIFO is full
module fir_out_decimator #(
    parameter int IN_W       = 16,
    parameter int OUT_W      = 8,
    parameter int DECIM      = 4,
    parameter int SHIFT      = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [IN_W-1:0]                 y_in,
    input  logic                            in_valid,
    output logic [OUT_W-1:0]                out_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic                            sat_flag,
    output logic                            overflow,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level
);

    // Phase counter width; at least one bit, so that DECIM=1 still has a legal counter.
    localparam int PH_W   = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int LVL_W  = PTR_W + 1;
    localparam int RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;

    localparam logic [PH_W-1:0]  PHASE_LAST = PH_W'(DECIM - 1);
    // Half an output LSB, added before the shift. It is zero when no bits are dropped.
    localparam logic [IN_W:0]    ROUND_ADD  = (SHIFT > 0) ? ((IN_W+1)'(1) << RND_SH) : '0;
    localparam logic [IN_W:0]    MAX_R      = (IN_W+1)'((1 << OUT_W) - 1);
    localparam logic [LVL_W-1:0] LVL_FULL   = LVL_W'(FIFO_DEPTH);

    // ------------------------------------------------------------------
    // Decimation and arithmetic
    // ------------------------------------------------------------------
    logic [PH_W-1:0]  phase_reg;
    logic             keep;
    logic [IN_W:0]    rounded_sum;
    logic [IN_W:0]    shifted;
    logic             sat_now;
    logic [OUT_W-1:0] result;

    logic [OUT_W-1:0] s1_data_reg;
    logic             s1_valid_reg;
    logic             sat_flag_reg;

    assign keep = in_valid && (phase_reg == PHASE_LAST);

    // Round half-up, then saturate.
    // The sum uses one extra bit, so the rounding increment cannot wrap at full scale.
    always_comb begin
        rounded_sum = {1'b0, y_in} + ROUND_ADD;
        shifted     = rounded_sum >> SHIFT;
        sat_now     = (shifted > MAX_R);
        result      = sat_now ? {OUT_W{1'b1}} : shifted[OUT_W-1:0];
    end

    // Phase advances only on valid input and wraps after DECIM-1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase_reg <= '0;
        end else if (in_valid) begin
            phase_reg <= (phase_reg == PHASE_LAST) ? '0 : phase_reg + PH_W'(1);
        end
    end

    // Stage 1: capture the kept result together with its saturation status.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_data_reg  <= '0;
            s1_valid_reg <= 1'b0;
            sat_flag_reg <= 1'b0;
        end else begin
            s1_valid_reg <= keep;
            sat_flag_reg <= keep && sat_now;
            if (keep) begin
                s1_data_reg <= result;
            end
        end
    end

    // ------------------------------------------------------------------
    // Show-ahead FIFO
    // out_data_reg holds a copy of the head entry, so out_data never
    // depends on a memory read in the same cycle.
    // ------------------------------------------------------------------
    logic [OUT_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_inc;
    logic [LVL_W-1:0] level_reg;
    logic [LVL_W-1:0] level_next;
    logic [OUT_W-1:0] out_data_reg;
    logic             overflow_reg;

    logic             fifo_empty;
    logic             fifo_full;
    logic             pop;
    logic             push_ok;
    logic             drop;

    // Handshake decode.
    // When the FIFO is full, a push is still accepted if the sink pops in the
    // same cycle.
    always_comb begin
        fifo_empty = (level_reg == '0);
        fifo_full  = (level_reg == LVL_FULL);
        pop        = !fifo_empty && out_ready;
        push_ok    = s1_valid_reg && (!fifo_full || pop);
        drop       = s1_valid_reg && fifo_full && !pop;
        rd_ptr_inc = rd_ptr_reg + PTR_W'(1);
        level_next = level_reg + LVL_W'(push_ok) - LVL_W'(pop);
    end

    // Storage array with no reset; it is written only on an accepted push.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= s1_data_reg;
        end
    end

    // Pointers, occupancy and the sticky overflow flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            level_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_inc;
            end
            level_reg <= level_next;
            if (drop) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    // Head register update:
    //   - pop with a second entry stored: load that next entry.
    //   - pop of the last entry while a push arrives: take the pushed sample.
    //   - push into an empty FIFO: take the pushed sample.
    //   - otherwise: hold, so out_data keeps its last value while empty.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_data_reg <= '0;
        end else if (pop) begin
            if (level_reg > LVL_W'(1)) begin
                out_data_reg <= mem[rd_ptr_inc];
            end else if (push_ok) begin
                out_data_reg <= s1_data_reg;
            end
        end else if (fifo_empty && push_ok) begin
            out_data_reg <= s1_data_reg;
        end
    end

    assign out_data   = out_data_reg;
    assign out_valid  = !fifo_empty;
    assign sat_flag   = sat_flag_reg;
    assign overflow   = overflow_reg;
    assign fifo_level = level_reg;

endmodule
